dmem_tcm_responder: RTL and testbench

DMEM_TCM_RESPONDER -- requirements
Module: dmem_tcm_responder

---
 rtl/dmem_tcm_responder.sv | 217 +++++++++++++++++++++
 tb/tb_dmem_tcm_responder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_tcm_responder.sv
// ---------------------------------------------------------------------------
// dmem_tcm_responder
//
// Tightly-coupled data memory responder. Accepts one load/store request at a
// time, commits stores and samples loads at the acceptance edge, then returns
// a single-cycle response LATENCY cycles later.
//
// Parameters
//   BASE_ADDR  byte address of memory word 0 (4-byte aligned)
//   MEM_WORDS  depth of the 32-bit memory array (power of two, 16..65536)
//   LATENCY    cycles from acceptance to response (1..4)
//
// Ports
//   clk           single clock, rising edge
//   rst           synchronous active-high reset (memory contents retained)
//   dmem_req      request valid
//   dmem_cmd      0 = read, 1 = write
//   dmem_width    00 = byte, 01 = half, 10 = word, 11 = reserved (error)
//   dmem_addr     byte address
//   dmem_wdata    LSB-justified write data
//   dmem_req_ack  high whenever the responder is idle (request accepted)
//   dmem_rdata    read data, non-zero only alongside an RDY response
//   dmem_resp     00 = IDLE, 01 = RDY, 10 = ER
//
// Optional feature
//   DMEM_RESP_MISALIGN_ERR_EN  when defined, half accesses with addr[0]=1 and
//   word accesses with addr[1:0]!=0 are rejected with ER. When undefined they
//   are serviced on the reachable lanes; bytes past bit 31 are dropped.
// ---------------------------------------------------------------------------
module dmem_tcm_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_req,
  input  logic        dmem_cmd,
  input  logic [1:0]  dmem_width,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic        dmem_req_ack,
  output logic [31:0] dmem_rdata,
  output logic [1:0]  dmem_resp
);

  localparam int unsigned AW         = $clog2(MEM_WORDS);
  localparam logic [31:0] SPAN       = 32'(4 * MEM_WORDS);
  localparam int unsigned CNT_INIT_I = (LATENCY > 1) ? (LATENCY - 2) : 0;
  localparam logic [1:0]  CNT_INIT   = 2'(CNT_INIT_I);

  localparam logic [1:0] RESP_IDLE = 2'b00;
  localparam logic [1:0] RESP_RDY  = 2'b01;
  localparam logic [1:0] RESP_ER   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [1:0]  cnt;
  logic [1:0]  cnt_n;

  logic [31:0] mem [MEM_WORDS];

  // Request decode
  logic [31:0]   offset;
  logic          in_range;
  logic          width_ok;
  logic          misalign;
  logic          req_err;
  logic [1:0]    lane;
  logic [3:0]    be_base;
  logic [3:0]    be;
  logic [31:0]   wdata_sh;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic [31:0]   rd_shift;
  logic          accept;
  logic          do_write;

  // Response holding registers
  logic          err_q;
  logic [31:0]   rdata_q;

  // -------------------------------------------------------------------------
  // Address / width decode
  // -------------------------------------------------------------------------
  always_comb begin
    offset = dmem_addr - BASE_ADDR;
    // offset is exact whenever addr >= BASE_ADDR, so the upper bound can be
    // checked on the offset without any carry-out concerns.
    in_range = (dmem_addr >= BASE_ADDR) && (offset < SPAN);
    width_ok = (dmem_width != 2'b11);
    lane     = dmem_addr[1:0];
    idx      = offset[AW+1:2];

    unique case (dmem_width)
      2'b00:   be_base = 4'b0001;
      2'b01:   be_base = 4'b0011;
      2'b10:   be_base = 4'b1111;
      default: be_base = 4'b0000;
    endcase

    // Shifting within fixed widths discards lanes that run past byte 3.
    be       = be_base << lane;
    wdata_sh = dmem_wdata << {lane, 3'b000};

`ifdef DMEM_RESP_MISALIGN_ERR_EN
    misalign = ((dmem_width == 2'b01) && dmem_addr[0]) ||
               ((dmem_width == 2'b10) && (dmem_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif

    req_err  = !width_ok || !in_range || misalign;
    accept   = dmem_req && (state == ST_IDLE) && !rst;
    do_write = accept && dmem_cmd && !req_err;
  end

  // Read path: memory is sampled combinationally and captured at acceptance.
  always_comb begin
    rd_word  = mem[idx];
    rd_shift = rd_word >> {lane, 3'b000};
  end

  // -------------------------------------------------------------------------
  // Memory array (never cleared by reset)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (dmem_req) begin
          if (LATENCY <= 1) begin
            state_n = ST_RESP;
          end else begin
            state_n = ST_WAIT;
            cnt_n   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == 2'd0) begin
          state_n = ST_RESP;
        end else begin
          cnt_n = cnt - 2'd1;
        end
      end
      ST_RESP: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Response capture: result is fixed at acceptance, inputs after that are
  // ignored. Writes and errors report zero data.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else if (accept) begin
      err_q   <= req_err;
      rdata_q <= (req_err || dmem_cmd) ? '0 : rd_shift;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    dmem_req_ack = (state == ST_IDLE);
    dmem_resp    = RESP_IDLE;
    dmem_rdata   = '0;
    if (state == ST_RESP) begin
      dmem_resp  = err_q ? RESP_ER : RESP_RDY;
      dmem_rdata = rdata_q;
    end
  end

endmodule

// File: tb/tb_dmem_tcm_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_tcm_responder
//
// Directed bench for dmem_tcm_responder. Three instances share the clock,
// reset and request payload; each has its own request strobe and outputs.
//   dut 0: BASE 0x0000, 1024 words, LATENCY 1
//   dut 1: BASE 0x1000,   16 words, LATENCY 2
//   dut 2: BASE 0x0000,   64 words, LATENCY 3
// Instance d therefore has latency d+1.
// ---------------------------------------------------------------------------
module tb_dmem_tcm_responder;

  localparam logic [1:0] R_IDLE = 2'b00;
  localparam logic [1:0] R_RDY  = 2'b01;
  localparam logic [1:0] R_ER   = 2'b10;

  localparam logic [1:0] W_B  = 2'b00;
  localparam logic [1:0] W_H  = 2'b01;
  localparam logic [1:0] W_W  = 2'b10;
  localparam logic [1:0] W_RS = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        req [3];
  logic        cmd;
  logic [1:0]  width;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack [3];
  logic [31:0] rdata [3];
  logic [1:0]  resp [3];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_tcm_responder #(.BASE_ADDR(32'h0000_0000), .MEM_WORDS(1024), .LATENCY(1)) u_dut0 (
    .clk(clk), .rst(rst), .dmem_req(req[0]), .dmem_cmd(cmd), .dmem_width(width),
    .dmem_addr(addr), .dmem_wdata(wdata), .dmem_req_ack(ack[0]),
    .dmem_rdata(rdata[0]), .dmem_resp(resp[0])
  );

  dmem_tcm_responder #(.BASE_ADDR(32'h0000_1000), .MEM_WORDS(16), .LATENCY(2)) u_dut1 (
    .clk(clk), .rst(rst), .dmem_req(req[1]), .dmem_cmd(cmd), .dmem_width(width),
    .dmem_addr(addr), .dmem_wdata(wdata), .dmem_req_ack(ack[1]),
    .dmem_rdata(rdata[1]), .dmem_resp(resp[1])
  );

  dmem_tcm_responder #(.BASE_ADDR(32'h0000_0000), .MEM_WORDS(64), .LATENCY(3)) u_dut2 (
    .clk(clk), .rst(rst), .dmem_req(req[2]), .dmem_cmd(cmd), .dmem_width(width),
    .dmem_addr(addr), .dmem_wdata(wdata), .dmem_req_ack(ack[2]),
    .dmem_rdata(rdata[2]), .dmem_resp(resp[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full transaction on instance d, entered and left at posedge+1.
  task automatic txn(input int d, input logic c, input logic [1:0] w,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [1:0] er, input logic [31:0] ed, input string tag);
    int lat;
    lat   = d + 1;
    cmd   = c;
    width = w;
    addr  = a;
    wdata = wd;
    req[d] = 1'b1;
    chk({tag, ".ack_idle"}, 32'(ack[d]), 32'd1);
    @(posedge clk); #1;
    // Scramble the payload: a correct responder must have captured it already.
    req[d] = 1'b0;
    cmd    = ~c;
    addr   = ~a;
    wdata  = ~wd;
    for (int i = 1; i < lat; i++) begin
      chk({tag, ".ack_wait"}, 32'(ack[d]), 32'd0);
      chk({tag, ".resp_wait"}, 32'(resp[d]), 32'(R_IDLE));
      @(posedge clk); #1;
    end
    chk({tag, ".resp"}, 32'(resp[d]), 32'(er));
    chk({tag, ".rdata"}, rdata[d], ed);
    chk({tag, ".ack_resp"}, 32'(ack[d]), 32'd0);
    @(posedge clk); #1;
    chk({tag, ".resp_after"}, 32'(resp[d]), 32'(R_IDLE));
    chk({tag, ".ack_after"}, 32'(ack[d]), 32'd1);
  endtask

  // Start a transaction on instance 1 (latency 2) and reset it while in WAIT.
  task automatic abort_in_wait(input logic c, input logic [31:0] a,
                               input logic [31:0] wd, input string tag);
    cmd    = c;
    width  = W_W;
    addr   = a;
    wdata  = wd;
    req[1] = 1'b1;
    @(posedge clk); #1;
    req[1] = 1'b0;
    chk({tag, ".ack_wait"}, 32'(ack[1]), 32'd0);
    chk({tag, ".resp_wait"}, 32'(resp[1]), 32'(R_IDLE));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk({tag, ".resp_rst"}, 32'(resp[1]), 32'(R_IDLE));
    chk({tag, ".rdata_rst"}, rdata[1], 32'h0);
    chk({tag, ".ack_rst"}, 32'(ack[1]), 32'd1);
    @(posedge clk); #1;
    chk({tag, ".resp_late"}, 32'(resp[1]), 32'(R_IDLE));
    chk({tag, ".ack_late"}, 32'(ack[1]), 32'd1);
  endtask

  initial begin
    rst   = 1'b1;
    req[0] = 1'b0;
    req[1] = 1'b0;
    req[2] = 1'b0;
    cmd   = 1'b0;
    width = W_W;
    addr  = '0;
    wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst%0d.ack", d), 32'(ack[d]), 32'd1);
      chk($sformatf("rst%0d.resp", d), 32'(resp[d]), 32'(R_IDLE));
      chk($sformatf("rst%0d.rdata", d), rdata[d], 32'h0);
    end

    // Idle with no request stays idle
    repeat (3) @(posedge clk);
    #1;
    chk("idle.ack", 32'(ack[0]), 32'd1);
    chk("idle.resp", 32'(resp[0]), 32'(R_IDLE));

    // Latency 1: word write then read back
    txn(0, 1'b1, W_W, 32'h10, 32'hDEADBEEF, R_RDY, 32'h0,        "l1_wr10");
    txn(0, 1'b0, W_W, 32'h10, 32'h0,        R_RDY, 32'hDEADBEEF, "l1_rd10");

    // Sub-word reads are shifted but not masked
    txn(0, 1'b1, W_W, 32'h10, 32'hCAFEF00D, R_RDY, 32'h0,        "wr_cafe");
    txn(0, 1'b0, W_H, 32'h12, 32'h0,        R_RDY, 32'h0000CAFE, "rd_half12");
    txn(0, 1'b0, W_B, 32'h11, 32'h0,        R_RDY, 32'h00CAFEF0, "rd_byte11");

    // Errors: first address past the end, reserved width
    txn(0, 1'b0, W_W,  32'h1000, 32'h0,        R_ER, 32'h0, "rd_oob");
    txn(0, 1'b0, W_RS, 32'h10,   32'h0,        R_ER, 32'h0, "rd_rsvd");
    txn(0, 1'b1, W_RS, 32'h10,   32'h12345678, R_ER, 32'h0, "wr_rsvd");
    txn(0, 1'b1, W_W,  32'h0,    32'h0BADF00D, R_RDY, 32'h0, "wr_w0");
    // 0x1000 aliases word 0 in the index bits; it must not write it
    txn(0, 1'b1, W_W,  32'h1000, 32'h55555555, R_ER, 32'h0, "wr_oob");
    txn(0, 1'b0, W_W,  32'h0,    32'h0, R_RDY, 32'h0BADF00D, "rd_w0_kept");
    txn(0, 1'b0, W_W,  32'h10,   32'h0, R_RDY, 32'hCAFEF00D, "rd10_kept");

    // Last valid word
    txn(0, 1'b1, W_W, 32'hFFC, 32'h01020304, R_RDY, 32'h0,        "wr_last");
    txn(0, 1'b0, W_W, 32'hFFC, 32'h0,        R_RDY, 32'h01020304, "rd_last");

    // Misaligned accesses
    txn(0, 1'b1, W_W, 32'h20, 32'h11111111, R_RDY, 32'h0, "wr20");
`ifdef DMEM_RESP_MISALIGN_ERR_EN
    txn(0, 1'b1, W_W, 32'h21, 32'hAABBCCDD, R_ER,  32'h0,        "wr_w21");
    txn(0, 1'b0, W_W, 32'h20, 32'h0,        R_RDY, 32'h11111111, "rd20_a");
    txn(0, 1'b1, W_H, 32'h23, 32'h0000BEEF, R_ER,  32'h0,        "wr_h23");
    txn(0, 1'b0, W_W, 32'h20, 32'h0,        R_RDY, 32'h11111111, "rd20_b");
    txn(0, 1'b0, W_H, 32'h23, 32'h0,        R_ER,  32'h0,        "rd_h23");
`else
    txn(0, 1'b1, W_W, 32'h21, 32'hAABBCCDD, R_RDY, 32'h0,        "wr_w21");
    txn(0, 1'b0, W_W, 32'h20, 32'h0,        R_RDY, 32'hBBCCDD11, "rd20_a");
    txn(0, 1'b1, W_H, 32'h23, 32'h0000BEEF, R_RDY, 32'h0,        "wr_h23");
    txn(0, 1'b0, W_W, 32'h20, 32'h0,        R_RDY, 32'hEFCCDD11, "rd20_b");
    txn(0, 1'b0, W_H, 32'h23, 32'h0,        R_RDY, 32'h000000EF, "rd_h23");
`endif

    // Latency 3: byte merge, upper wdata bits must be ignored
    txn(2, 1'b1, W_W, 32'h10, 32'h11223344, R_RDY, 32'h0,        "l3_wr10");
    txn(2, 1'b1, W_B, 32'h13, 32'h123456A5, R_RDY, 32'h0,        "l3_wrb13");
    txn(2, 1'b0, W_W, 32'h10, 32'h0,        R_RDY, 32'hA5223344, "l3_rd10");
    txn(2, 1'b0, W_W, 32'h100, 32'h0,       R_ER,  32'h0,        "l3_oob");

    // Latency 2 with non-zero base
    txn(1, 1'b1, W_W, 32'h1030, 32'h12345678, R_RDY, 32'h0,        "l2_wr30");
    txn(1, 1'b0, W_W, 32'h1030, 32'h0,        R_RDY, 32'h12345678, "l2_rd30");
    txn(1, 1'b0, W_W, 32'h0FFC, 32'h0,        R_ER,  32'h0,        "l2_below");
    txn(1, 1'b0, W_W, 32'h1040, 32'h0,        R_ER,  32'h0,        "l2_above");

    // Reset during WAIT aborts the response; committed write survives
    abort_in_wait(1'b1, 32'h1034, 32'hA0A0A0A0, "abort_wr");
    abort_in_wait(1'b0, 32'h1030, 32'h0,        "abort_rd");
    txn(1, 1'b0, W_W, 32'h1034, 32'h0, R_RDY, 32'hA0A0A0A0, "l2_rd34");
    txn(1, 1'b0, W_W, 32'h1030, 32'h0, R_RDY, 32'h12345678, "l2_rd30b");

    // Memory not cleared by reset
    txn(0, 1'b0, W_W, 32'h10, 32'h0, R_RDY, 32'hCAFEF00D, "rd10_postrst");
    txn(2, 1'b0, W_W, 32'h10, 32'h0, R_RDY, 32'hA5223344, "l3_postrst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
